// File: rtl/fp_regfile_wb.sv
// 32x32 floating-point register file with a single-outstanding-op scoreboard,
// a load skid buffer behind the single write port, and fcsr (fflags/frm).
module fp_regfile_wb #(
    parameter bit         BYPASS    = 1'b1,
    parameter logic [2:0] RESET_FRM = 3'b000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [4:0]  rs1_sel,
    input  logic [4:0]  rs2_sel,
    output logic [31:0] f_rs1_data,
    output logic [31:0] f_rs2_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic        f_ready,
    input  logic [31:0] FPU_out,
    input  logic [4:0]  flags,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic [2:0]  instr_rm,
    output logic [2:0]  frm,
    output logic        frm_illegal,
    input  logic        csr_wen,
    input  logic [1:0]  csr_addr,
    input  logic [7:0]  csr_wdata,
    output logic [7:0]  csr_rdata,
    output logic        busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [31:0] regs_q [32];
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] pending_q, pending_d;
    logic        skid_valid_q, skid_valid_d;
    logic [4:0]  skid_rd_q, skid_rd_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [4:0]  fflags_q, fflags_d;
    logic [2:0]  frm_q, frm_d;

    logic        fpu_wb;
    logic        ld_acc;
    logic        skid_hit;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    assign busy     = (state_q == BUSY);
    assign fpu_wb   = busy && f_ready;
    assign skid_hit = skid_valid_q &&
                      (skid_rd_q == rs1_sel || skid_rd_q == rs2_sel || skid_rd_q == issue_rd);
    assign issue_ready = (state_q == IDLE) && !skid_hit;
    assign ld_ready    = !skid_valid_q && !(busy && ld_rd == wb_rd_q);
    assign ld_acc      = ld_valid && ld_ready;

    // Single write port: FPU result beats the skid drain, which beats a fresh load.
    always_comb begin
        wen   = 1'b0;
        waddr = '0;
        wdata = '0;
        if (fpu_wb) begin
            wen   = 1'b1;
            waddr = wb_rd_q;
            wdata = FPU_out;
        end else if (skid_valid_q) begin
            wen   = 1'b1;
            waddr = skid_rd_q;
            wdata = skid_data_q;
        end else if (ld_acc) begin
            wen   = 1'b1;
            waddr = ld_rd;
            wdata = ld_data;
        end
    end

    assign f_rs1_data = (BYPASS && wen && waddr == rs1_sel) ? wdata : regs_q[rs1_sel];
    assign f_rs2_data = (BYPASS && wen && waddr == rs2_sel) ? wdata : regs_q[rs2_sel];

    always_comb begin
        state_d      = state_q;
        wb_rd_d      = wb_rd_q;
        pending_d    = pending_q;
        skid_valid_d = skid_valid_q;
        skid_rd_d    = skid_rd_q;
        skid_data_d  = skid_data_q;
        case (state_q)
            IDLE: if (issue_valid && issue_ready) begin
                state_d             = BUSY;
                wb_rd_d             = issue_rd;
                pending_d[issue_rd] = 1'b1;
            end
            BUSY: if (f_ready) begin
                state_d            = IDLE;
                pending_d[wb_rd_q] = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // A load colliding with the FPU writeback parks here until the port is free.
        if (fpu_wb && ld_acc) begin
            skid_valid_d = 1'b1;
            skid_rd_d    = ld_rd;
            skid_data_d  = ld_data;
        end else if (skid_valid_q && !fpu_wb) begin
            skid_valid_d = 1'b0;
        end
    end

    always_comb begin
        fflags_d = fflags_q;
        frm_d    = frm_q;
        if (csr_wen) begin
            case (csr_addr)
                2'b01: fflags_d = csr_wdata[4:0];
                2'b10: frm_d    = csr_wdata[2:0];
                2'b11: begin
                    frm_d    = csr_wdata[7:5];
                    fflags_d = csr_wdata[4:0];
                end
                default: ;
            endcase
        end
        if (fpu_wb)
            fflags_d = fflags_d | flags;
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            2'b01:   csr_rdata = {3'b000, fflags_q};
            2'b10:   csr_rdata = {5'b00000, frm_q};
            2'b11:   csr_rdata = {frm_q, fflags_q};
            default: csr_rdata = '0;
        endcase
    end

    assign frm         = (instr_rm == 3'b111) ? frm_q : instr_rm;
    assign frm_illegal = (frm == 3'b101) || (frm == 3'b110) || (frm == 3'b111);

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q      <= IDLE;
            wb_rd_q      <= '0;
            pending_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_rd_q    <= '0;
            skid_data_q  <= '0;
            fflags_q     <= '0;
            frm_q        <= RESET_FRM;
        end else begin
            state_q      <= state_d;
            wb_rd_q      <= wb_rd_d;
            pending_q    <= pending_d;
            skid_valid_q <= skid_valid_d;
            skid_rd_q    <= skid_rd_d;
            skid_data_q  <= skid_data_d;
            fflags_q     <= fflags_d;
            frm_q        <= frm_d;
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            for (int i = 0; i < 32; i++)
                regs_q[i] <= '0;
        end else if (wen) begin
            regs_q[waddr] <= wdata;
        end
    end

endmodule

// File: doc/fp_regfile_wb.md
Name: fp_regfile_wb

Overview:
- Register-file end of the FPU operand/result path: a 32x32 floating-point register file with a one-outstanding-op scoreboard toward the FPU.
- Supplies rs1/rs2 operands and the resolved rounding mode to the FPU.
- Retires FPU results and memory loads into the array, and accumulates sticky exception flags into fcsr.
- Sits between decode/issue, the FPU core and the load return path.

Parameters:
- BYPASS, 1, 1 = a read port returns data written in the same cycle; 0 = the array value is returned.
- RESET_FRM, 3'b000, value of fcsr.frm after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- n_rst  in  1  asynchronous, active-high reset (asserted = 1).
- rs1_sel  in  5  operand 1 register index.
- rs2_sel  in  5  operand 2 register index.
- f_rs1_data  out  32  operand 1 data.
- f_rs2_data  out  32  operand 2 data.
- issue_valid  in  1  decode requests an FPU op writing issue_rd.
- issue_rd  in  5  destination register of the issued op.
- issue_ready  out  1  op may be accepted this cycle.
- f_ready  in  1  FPU result valid.
- FPU_out  in  32  FPU result.
- flags  in  5  {NV,DZ,OF,UF,NX} accompanying FPU_out.
- ld_valid  in  1  load data valid.
- ld_rd  in  5  load destination register.
- ld_data  in  32  load data.
- ld_ready  out  1  load accepted this cycle.
- instr_rm  in  3  instruction rounding mode field.
- frm  out  3  resolved rounding mode to the FPU.
- frm_illegal  out  1  resolved mode is reserved.
- csr_wen  in  1  CSR write strobe.
- csr_addr  in  2  01 = fflags, 10 = frm, 11 = fcsr (00 = no-op).
- csr_wdata  in  8  CSR write data.
- csr_rdata  out  8  CSR read data.
- busy  out  1  FPU op outstanding.

Behaviour:
- Reset (async, n_rst=1):
  - all 32 registers = 0; fflags = 0; fcsr.frm = RESET_FRM.
  - pending[31:0] = 0; skid buffer empty; FSM = IDLE.
  - Outputs: busy=0, issue_ready=1 when issue_valid=0, ld_ready=1.
  - Reset asserted mid-operation abandons the outstanding op. A subsequent f_ready pulse in IDLE is ignored.
- Reads are combinational: f_rsN_data = array[rsN_sel].
  - With BYPASS=1, an array write occurring this cycle to the same index is forwarded instead.
  - Register 0 is an ordinary register (FP file, not hardwired).
- FSM IDLE/BUSY:
  - IDLE -> BUSY on issue_valid && issue_ready. Latch issue_rd into wb_rd and set pending[issue_rd].
  - BUSY -> IDLE on f_ready. Write FPU_out to array[wb_rd], clear pending[wb_rd], apply fflags |= flags.
  - busy = (state==BUSY).
  - f_ready in IDLE: no write, no flag update.
- issue_ready = IDLE && !skid_full_hit, where skid_full_hit = skid valid && skid_rd ∈ {rs1_sel, rs2_sel, issue_rd}. No issue is accepted in the writeback cycle.
- Loads: ld_ready = !skid_valid && !(busy && ld_rd==wb_rd), which blocks a WAW against the outstanding op.
  - Accepted load with no FPU writeback this cycle: written to array directly.
  - Accepted load in the same cycle as an FPU writeback: the FPU write wins the port, and the load is captured in a 1-entry skid buffer (skid_valid=1, ld_ready=0 next cycle).
  - The skid buffer drains into the array on the first cycle without an FPU writeback, then clears.
  - Single write port only.
- Rounding mode:
  - frm = (instr_rm==3'b111) ? fcsr.frm : instr_rm.
  - frm_illegal = frm ∈ {3'b101, 3'b110, 3'b111}. A stored fcsr.frm of 111 is reported illegal.
- CSR:
  - csr_rdata: addr 01 -> {3'b0, fflags}; 10 -> {5'b0, frm_reg}; 11 -> {frm_reg, fflags}; 00 -> 0.
  - Write on csr_wen: 01 sets fflags = wdata[4:0]; 10 sets frm_reg = wdata[2:0]; 11 sets both from wdata[7:5] and wdata[4:0].
  - CSR write coinciding with an FPU writeback: new fflags = csr-written value | flags. Flags are never lost.

Test Plan:
- Reset, then read all 32 indices -> every f_rs*_data = 0, csr_rdata(addr 11) = {RESET_FRM, 5'b0}, busy=0, ld_ready=1.
- Issue rd=5; three cycles later f_ready with FPU_out=32'h3F800000, flags=5'b00001 -> reg5 = 32'h3F800000, fflags = 00001, busy returns to 0. Issue with rs1_sel=5 while BUSY -> issue_ready=0.
- Load rd=7, data=32'hDEADBEEF, in the same cycle as FPU writeback to rd=5 -> reg5 written that cycle; ld_ready=0 next cycle; reg7 = DEADBEEF one cycle later. A read of rs1=7 in the drain cycle with BYPASS=1 returns DEADBEEF.
- csr_wen addr 11, wdata 8'h40, same cycle as f_ready flags=5'b10000 -> frm_reg=3'b010, fflags=5'b10000. instr_rm=111 -> frm=010, frm_illegal=0. Write frm=101 -> frm_illegal=1.
- Issue rd=3, then assert n_rst mid-BUSY, then deassert, then f_ready with FPU_out=1 -> reg3 stays 0, fflags stays 0, pending cleared, issue_ready=1.
- Load to rd=9 while an FPU op to rd=9 is outstanding -> ld_ready=0 until the writeback cycle completes.
